// File: rtl/alif_multi_channel_system_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package    : alif_pkg                                                      |
// | Purpose    : Shared definitions for the adaptive-LIF neuron tile: frame    |
// |              length helper, parameter-field offsets inside a committed     |
// |              frame, and the serial loader state encoding.                  |
// | Ports      : none (package)                                                |
// | Revision   : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package alif_pkg;

  // Frame layout, LSB-relative once the whole frame has been shifted in
  // (the first bit sent ends up at the MSB):
  //   [OFS_WGT +: NUM_CH*WGT_W]  w[NUM_CH-1] (MSB) .. w[0]
  //   [OFS_LEAK_RATE +: 8]       leak_rate
  //   [OFS_THR_MIN +: 8]         thr_min
  //   [OFS_LEAK_CYC +: 4]        leak_cycles
  //   [OFS_THR_INC +: 8]         thr_inc
  localparam int OFS_THR_INC   = 0;
  localparam int OFS_LEAK_CYC  = 8;
  localparam int OFS_THR_MIN   = 12;
  localparam int OFS_LEAK_RATE = 20;
  localparam int OFS_WGT       = 28;
  localparam int FIXED_BITS    = 28;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_SHIFT = 2'd1,
    LD_DONE  = 2'd2
  } ld_state_e;

  function automatic int frame_len(input int num_ch, input int wgt_w);
    return num_ch * wgt_w + FIXED_BITS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alif_multi_channel_system_if.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Interface  : alif_multi_channel_system_if                                  |
// | Purpose    : Groups the neuron tile control, data and status signals.      |
// | Signals    : enable, input_enable, chan_in, load_mode, serial_data (to     |
// |              tile); spike_out, v_mem_out, thr_out, params_ready (from tile)|
// | Modports   : master = driver of the tile, slave = the tile itself          |
// | Revision   : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

interface alif_multi_channel_system_if #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 3,
  parameter int V_W    = 8
);

  logic                   enable;
  logic                   input_enable;
  logic [NUM_CH*IN_W-1:0] chan_in;
  logic                   load_mode;
  logic                   serial_data;
  logic                   spike_out;
  logic [V_W-1:0]         v_mem_out;
  logic [V_W-1:0]         thr_out;
  logic                   params_ready;

  modport master (
    output enable, input_enable, chan_in, load_mode, serial_data,
    input  spike_out, v_mem_out, thr_out, params_ready
  );

  modport slave (
    input  enable, input_enable, chan_in, load_mode, serial_data,
    output spike_out, v_mem_out, thr_out, params_ready
  );

endinterface

`default_nettype wire

// File: rtl/alif_multi_channel_system_loader.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module     : alif_multi_channel_loader                                     |
// | Purpose    : Serial parameter loader. Shifts an MSB-first frame into a     |
// |              shadow register, commits it to the live parameters when the   |
// |              last bit arrives, discards partial frames.                    |
// | Ports      : clk, reset (async, active-low)                                |
// |              enable_i, load_mode_i, serial_data_i   frame input            |
// |              weights_o, leak_rate_o, thr_min_o,                            |
// |              leak_cycles_o, thr_inc_o               live parameters        |
// |              commit_o, commit_thr_min_o             one-cycle commit strobe|
// |              params_ready_o                         frame committed        |
// | Revision   : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module alif_multi_channel_loader
  import alif_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WGT_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    load_mode_i,
  input  logic                    serial_data_i,
  output logic [NUM_CH*WGT_W-1:0] weights_o,
  output logic [7:0]              leak_rate_o,
  output logic [7:0]              thr_min_o,
  output logic [3:0]              leak_cycles_o,
  output logic [7:0]              thr_inc_o,
  output logic                    commit_o,
  output logic [7:0]              commit_thr_min_o,
  output logic                    params_ready_o
);

  localparam int FRAME_LEN = frame_len(NUM_CH, WGT_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  ld_state_e              state_q, state_d;
  // Only FRAME_LEN-1 bits are kept: the incoming bit completes the frame.
  logic [FRAME_LEN-2:0]   shadow_q, shadow_d;
  logic [FRAME_LEN-1:0]   live_q, live_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic [FRAME_LEN-1:0]   shifted;
  logic                   commit;

  assign shifted = {shadow_q, serial_data_i};

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    live_d   = live_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    commit   = 1'b0;
    if (enable_i) begin
      case (state_q)
        LD_IDLE: begin
          if (load_mode_i) begin
            shadow_d = shifted[FRAME_LEN-2:0];
            cnt_d    = CNT_W'(1);
            state_d  = LD_SHIFT;
          end
        end
        LD_SHIFT: begin
          if (load_mode_i) begin
            shadow_d = shifted[FRAME_LEN-2:0];
            if (cnt_q == LAST_BIT) begin
              live_d  = shifted;
              ready_d = 1'b1;
              commit  = 1'b1;
              cnt_d   = '0;
              state_d = LD_DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            // Partial frame: drop it, live parameters and ready flag untouched.
            cnt_d   = '0;
            state_d = LD_IDLE;
          end
        end
        LD_DONE: begin
          if (!load_mode_i) state_d = LD_IDLE;
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LD_IDLE;
      shadow_q <= '0;
      live_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  assign weights_o        = live_q[OFS_WGT +: NUM_CH*WGT_W];
  assign leak_rate_o      = live_q[OFS_LEAK_RATE +: 8];
  assign thr_min_o        = live_q[OFS_THR_MIN +: 8];
  assign leak_cycles_o    = live_q[OFS_LEAK_CYC +: 4];
  assign thr_inc_o        = live_q[OFS_THR_INC +: 8];
  assign commit_o         = commit;
  // The neuron resets its threshold on the commit edge, before live_q updates.
  assign commit_thr_min_o = shifted[OFS_THR_MIN +: 8];
  // Ready reads low while a frame is in flight; an aborted frame restores it.
  assign params_ready_o   = ready_q && (state_q != LD_SHIFT);

endmodule

`default_nettype wire

// File: rtl/alif_multi_channel_system.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module     : alif_multi_channel_system                                     |
// | Purpose    : Adaptive-LIF neuron tile with NUM_CH weighted input channels, |
// |              serial parameter loader and an adaptive threshold that rises  |
// |              on each spike and decays on each leak tick.                   |
// | Ports      : clk    system clock                                           |
// |              reset  asynchronous, active-low                               |
// |              bus    alif_multi_channel_system_if.slave                     |
// |                     (enable, input_enable, chan_in, load_mode, serial_data |
// |                      in; spike_out, v_mem_out, thr_out, params_ready out)  |
// | Config     : ALIF_REFRACTORY_EN - when defined, integration is suppressed  |
// |              for REFRAC steps after each spike.                            |
// | Revision   : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module alif_multi_channel_system
  import alif_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 3,
  parameter int WGT_W  = 3,
  parameter int V_W    = 8,
  parameter int REFRAC = 3
) (
  input logic                         clk,
  input logic                         reset,
  alif_multi_channel_system_if.slave  bus
);

  localparam int PROD_W = IN_W + WGT_W;
  localparam int SUM_W  = PROD_W + $clog2(NUM_CH + 1);
  localparam int ACC_W  = ((SUM_W > V_W) ? SUM_W : V_W) + 1;
  localparam logic [V_W-1:0] V_MAX = '1;

  logic [NUM_CH*WGT_W-1:0] weights;
  logic [7:0]              leak_rate;
  logic [7:0]              thr_min;
  logic [3:0]              leak_cycles;
  logic [7:0]              thr_inc;
  logic                    commit;
  logic [7:0]              commit_thr_min;
  logic                    params_ready;

  alif_multi_channel_loader #(
    .NUM_CH (NUM_CH),
    .WGT_W  (WGT_W)
  ) u_loader (
    .clk              (clk),
    .reset            (reset),
    .enable_i         (bus.enable),
    .load_mode_i      (bus.load_mode),
    .serial_data_i    (bus.serial_data),
    .weights_o        (weights),
    .leak_rate_o      (leak_rate),
    .thr_min_o        (thr_min),
    .leak_cycles_o    (leak_cycles),
    .thr_inc_o        (thr_inc),
    .commit_o         (commit),
    .commit_thr_min_o (commit_thr_min),
    .params_ready_o   (params_ready)
  );

  logic [V_W-1:0]  v_q, v_d;
  logic [V_W-1:0]  thr_q, thr_d;
  logic [3:0]      leak_cnt_q, leak_cnt_d;
  logic            spike_q, spike_d;

  logic [PROD_W-1:0] prod [NUM_CH];
  logic [SUM_W-1:0]  sum;
  logic [ACC_W-1:0]  acc;
  logic [V_W-1:0]    v1;
  logic [V_W-1:0]    thr_dec;
  logic [V_W:0]      thr_sum;
  logic [V_W-1:0]    thr_up;
  logic [V_W-1:0]    leak_rate_v;
  logic [V_W-1:0]    thr_min_v;
  logic [V_W-1:0]    thr_inc_v;
  logic              tick;
  logic              fire;
  logic              step;
  logic              in_refrac;

  assign leak_rate_v = V_W'(leak_rate);
  assign thr_min_v   = V_W'(thr_min);
  assign thr_inc_v   = V_W'(thr_inc);
  assign step        = bus.enable && bus.input_enable && params_ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_prod
      assign prod[gi] = PROD_W'(bus.chan_in[gi*IN_W +: IN_W]) *
                        PROD_W'(weights[gi*WGT_W +: WGT_W]);
    end
  endgenerate

  // Step datapath: integrate (saturating), optional leak tick, fire check.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
    if (in_refrac) sum = '0;
    acc = ACC_W'(v_q) + ACC_W'(sum);
    v1  = (acc > ACC_W'(V_MAX)) ? V_MAX : acc[V_W-1:0];

    tick    = (leak_cycles != 4'd0) && (leak_cnt_q == leak_cycles - 4'd1);
    thr_dec = thr_q;
    if (tick) begin
      v1 = (v1 > leak_rate_v) ? (v1 - leak_rate_v) : '0;
      if (thr_q > thr_min_v) thr_dec = thr_q - V_W'(1);
    end

    fire    = (v1 >= thr_dec) && !in_refrac;
    // Increment rides on top of the already-decayed threshold.
    thr_sum = {1'b0, thr_dec} + {1'b0, thr_inc_v};
    thr_up  = thr_sum[V_W] ? V_MAX : thr_sum[V_W-1:0];
  end

  always_comb begin
    spike_d    = 1'b0;
    v_d        = v_q;
    thr_d      = thr_q;
    leak_cnt_d = leak_cnt_q;
    if (commit) begin
      v_d        = '0;
      thr_d      = V_W'(commit_thr_min);
      leak_cnt_d = '0;
    end else if (step) begin
      spike_d    = fire;
      v_d        = fire ? '0 : v1;
      thr_d      = fire ? thr_up : thr_dec;
      if (tick) begin
        leak_cnt_d = '0;
      end else if (leak_cycles != 4'd0) begin
        leak_cnt_d = leak_cnt_q + 4'd1;
      end else begin
        leak_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q        <= '0;
      thr_q      <= '0;
      leak_cnt_q <= '0;
      spike_q    <= 1'b0;
    end else begin
      v_q        <= v_d;
      thr_q      <= thr_d;
      leak_cnt_q <= leak_cnt_d;
      spike_q    <= spike_d;
    end
  end

`ifdef ALIF_REFRACTORY_EN
  localparam int RC_W = $clog2(REFRAC + 1);

  logic [RC_W-1:0] refrac_q, refrac_d;

  assign in_refrac = (refrac_q != '0);

  always_comb begin
    refrac_d = refrac_q;
    if (commit) begin
      refrac_d = '0;
    end else if (step) begin
      if (fire) begin
        refrac_d = RC_W'(REFRAC);
      end else if (in_refrac) begin
        refrac_d = refrac_q - RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refrac_q <= '0;
    end else begin
      refrac_q <= refrac_d;
    end
  end
`else
  assign in_refrac = 1'b0;
  // REFRAC has no effect in this build; fold it into a sink.
  logic unused_refrac;
  assign unused_refrac = ^REFRAC;
`endif

  assign bus.spike_out    = spike_q;
  assign bus.v_mem_out    = v_q;
  assign bus.thr_out      = thr_q;
  assign bus.params_ready = params_ready;

endmodule

`default_nettype wire
